// File: rtl/pac_mover.sv
// pac_mover: writer side of the 40x30 tile map. Owns Pac-Man's tile
// position, checks the target tile for walls through RAM port B, redraws
// the old and new tiles on a legal move, and tracks score and dots left.
// RAM-facing outputs and the status pulses are registered; each one is
// loaded on the edge that enters the state that owns it.
module pac_mover #(
  parameter logic [5:0]  START_COL  = 6'd19,
  parameter logic [4:0]  START_ROW  = 5'd22,
  parameter logic [7:0]  DOTS_TOTAL = 8'd240,
  parameter logic [15:0] DOT_PTS    = 16'd10,
  parameter logic [15:0] BIG_PTS    = 16'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [1:0]  dir,
  output logic [10:0] addr_b,
  output logic        we_b,
  output logic [2:0]  din_b,
  input  logic [2:0]  dout_b,
  output logic [5:0]  pac_col,
  output logic [4:0]  pac_row,
  output logic [15:0] score,
  output logic [7:0]  dots_left,
  output logic        busy,
  output logic        moved,
  output logic        blocked,
  output logic        level_clear
);

  localparam logic [2:0] TILE_PAC = 3'b010;
  localparam logic [2:0] TILE_UT  = 3'b100;
  localparam logic [2:0] TILE_DOT = 3'b101;
  localparam logic [2:0] TILE_BIG = 3'b110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_NEXT  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHK   = 3'd4,
    ST_BLK   = 3'd5,
    ST_ERASE = 3'd6,
    ST_DRAW  = 3'd7
  } state_t;

  // row*40+col built from shifts so no multiplier is inferred
  function automatic logic [10:0] tile_addr(input logic [4:0] row, input logic [5:0] col);
    logic [10:0] w_row_ext;
    w_row_ext = {6'd0, row};
    return (w_row_ext << 5) + (w_row_ext << 3) + {5'd0, col};
  endfunction

  // Only path, dots, big dots and Pac-Man himself are walkable
  function automatic logic is_wall(input logic [2:0] code);
    logic w_wall;
    case (code)
      TILE_PAC, TILE_UT, TILE_DOT, TILE_BIG: w_wall = 1'b0;
      default:                               w_wall = 1'b1;
    endcase
    return w_wall;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_col, r_tgt_col, w_tgt_col;
  logic [4:0]  r_row, r_tgt_row, w_tgt_row;
  logic        r_oob, w_oob;
  logic [2:0]  r_tile;
  logic [15:0] r_score, w_pts, w_score_nxt;
  logic [16:0] w_sum;
  logic        w_dot_hit;
  logic [7:0]  r_dots, w_dots_nxt;
  logic [10:0] r_addr_b, w_addr_nxt;
  logic        r_we_b, w_we_nxt;
  logic [2:0]  r_din_b, w_din_nxt;
  logic        r_moved, w_moved_nxt;
  logic        r_blocked, w_blocked_nxt;

  // Target tile for the requested direction; left/right wrap through the tunnel
  always_comb begin
    w_tgt_col = r_col;
    w_tgt_row = r_row;
    w_oob     = 1'b0;
    case (dir)
      2'b00: begin
        if (r_col == 6'd39) w_tgt_col = 6'd0;
        else                w_tgt_col = r_col + 6'd1;
      end
      2'b01: begin
        if (r_row == 5'd0) w_oob = 1'b1;
        else               w_tgt_row = r_row - 5'd1;
      end
      2'b10: begin
        if (r_col == 6'd0) w_tgt_col = 6'd39;
        else               w_tgt_col = r_col - 6'd1;
      end
      2'b11: begin
        if (r_row == 5'd29) w_oob = 1'b1;
        else                w_tgt_row = r_row + 5'd1;
      end
      default: w_oob = 1'b1;
    endcase
  end

  // Score and dot bookkeeping for the tile being entered
  always_comb begin
    w_pts     = 16'd0;
    w_dot_hit = 1'b0;
    case (r_tile)
      TILE_DOT: begin w_pts = DOT_PTS; w_dot_hit = 1'b1; end
      TILE_BIG: begin w_pts = BIG_PTS; w_dot_hit = 1'b1; end
      default:  begin w_pts = 16'd0;   w_dot_hit = 1'b0; end
    endcase
    w_sum = {1'b0, r_score} + {1'b0, w_pts};
    if (w_sum[16]) w_score_nxt = 16'hFFFF;
    else           w_score_nxt = w_sum[15:0];
    if (w_dot_hit && (r_dots != 8'd0)) w_dots_nxt = r_dots - 8'd1;
    else                               w_dots_nxt = r_dots;
  end

  // Next state plus the RAM/pulse values owned by that next state
  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_addr_b;
    w_din_nxt     = r_din_b;
    w_moved_nxt   = 1'b0;
    w_blocked_nxt = 1'b0;
    case (r_state)
      ST_INIT: begin
        // First cycle after reset presents the start write, second retires it
        if (r_we_b) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = tile_addr(START_ROW, START_COL);
          w_din_nxt  = TILE_PAC;
        end
      end
      ST_IDLE: begin
        if (step) begin
          w_state_nxt = ST_NEXT;
          if (!w_oob) w_addr_nxt = tile_addr(w_tgt_row, w_tgt_col);
          else        w_addr_nxt = r_addr_b;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (r_oob) begin
          w_state_nxt   = ST_BLK;
          w_blocked_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: w_state_nxt = ST_CHK;
      ST_CHK: begin
        if (is_wall(dout_b)) begin
          w_state_nxt   = ST_BLK;
          w_blocked_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_ERASE;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = tile_addr(r_row, r_col);
          w_din_nxt   = TILE_UT;
        end
      end
      ST_BLK: w_state_nxt = ST_IDLE;
      ST_ERASE: begin
        w_state_nxt = ST_DRAW;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = tile_addr(r_tgt_row, r_tgt_col);
        w_din_nxt   = TILE_PAC;
        w_moved_nxt = 1'b1;
      end
      ST_DRAW: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State register and registered RAM-port / pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_INIT;
      r_we_b    <= 1'b0;
      r_addr_b  <= 11'd0;
      r_din_b   <= 3'b000;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_we_b    <= w_we_nxt;
      r_addr_b  <= w_addr_nxt;
      r_din_b   <= w_din_nxt;
      r_moved   <= w_moved_nxt;
      r_blocked <= w_blocked_nxt;
    end
  end

  // Move datapath: target latch, tile sample, and commit on DRAW
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col     <= START_COL;
      r_row     <= START_ROW;
      r_tgt_col <= START_COL;
      r_tgt_row <= START_ROW;
      r_oob     <= 1'b0;
      r_tile    <= TILE_UT;
      r_score   <= 16'd0;
      r_dots    <= DOTS_TOTAL;
    end else begin
      if ((r_state == ST_IDLE) && step) begin
        r_tgt_col <= w_tgt_col;
        r_tgt_row <= w_tgt_row;
        r_oob     <= w_oob;
      end
      if (r_state == ST_CHK) begin
        r_tile <= dout_b;
      end
      if (r_state == ST_DRAW) begin
        r_col   <= r_tgt_col;
        r_row   <= r_tgt_row;
        r_score <= w_score_nxt;
        r_dots  <= w_dots_nxt;
      end
    end
  end

  assign addr_b      = r_addr_b;
  assign we_b        = r_we_b;
  assign din_b       = r_din_b;
  assign moved       = r_moved;
  assign blocked     = r_blocked;
  assign pac_col     = r_col;
  assign pac_row     = r_row;
  assign score       = r_score;
  assign dots_left   = r_dots;
  assign busy        = (r_state != ST_IDLE);
  assign level_clear = (r_dots == 8'd0);

endmodule

// File: tb/tb_pac_mover.sv
// Testbench for pac_mover: behavioural tile RAM, write monitor feeding an
// observed queue, and an expected-write queue filled when a step is driven.
module tb_pac_mover;

  logic        clk = 1'b0;
  logic        rst, step, we_b, busy, moved, blocked, level_clear;
  logic [1:0]  dir;
  logic [10:0] addr_b;
  logic [2:0]  din_b, dout_b;
  logic [5:0]  pac_col;
  logic [4:0]  pac_row;
  logic [15:0] score;
  logic [7:0]  dots_left;

  logic        clr = 1'b1, pre_we = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [2:0]  pre_data = 3'b000;
  logic [2:0]  mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;
  int n_moved  = 0;
  int n_blocked = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  int m_col, m_row, m_score, m_dots;

  pac_mover dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir),
    .addr_b(addr_b), .we_b(we_b), .din_b(din_b), .dout_b(dout_b),
    .pac_col(pac_col), .pac_row(pac_row), .score(score), .dots_left(dots_left),
    .busy(busy), .moved(moved), .blocked(blocked), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  // Tile RAM port B: registered read, bench preload port, bulk clear to path
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 3'b100;
    end else begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (we_b) mem[addr_b] <= din_b;
    end
    dout_b <= mem[addr_b];
  end

  // Monitor: record every RAM write and count status pulses
  always @(negedge clk) begin
    if (we_b === 1'b1) obs_q.push_back({addr_b, din_b});
    if (moved === 1'b1) n_moved <= n_moved + 1;
    if (blocked === 1'b1) n_blocked <= n_blocked + 1;
  end

  function automatic bit model_wall(input logic [2:0] code);
    return !(code == 3'b010 || code == 3'b100 || code == 3'b101 || code == 3'b110);
  endfunction

  task automatic calc_target(input logic [1:0] d, output int tc, output int tr, output bit oob);
    tc = m_col; tr = m_row; oob = 1'b0;
    case (d)
      2'b00: tc = (m_col == 39) ? 0 : m_col + 1;
      2'b01: if (m_row == 0) oob = 1'b1; else tr = m_row - 1;
      2'b10: tc = (m_col == 0) ? 39 : m_col - 1;
      default: if (m_row == 29) oob = 1'b1; else tr = m_row + 1;
    endcase
  endtask

  task automatic preload(input logic [10:0] a, input logic [2:0] code);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = code;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, output int lat_m, output int lat_b);
    @(posedge clk); #1;
    step = 1'b1; dir = d;
    @(posedge clk); #1;
    step = 1'b0;
    lat_m = -1; lat_b = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (moved === 1'b1) begin lat_m = k; break; end
      if (blocked === 1'b1) begin lat_b = k; break; end
    end
    @(negedge clk);
  endtask

  // Preload target, queue expected writes, step, then advance the model
  task automatic move(input logic [1:0] d, input logic [2:0] code, output int lat_m, output int lat_b);
    int tc, tr; bit oob; logic [10:0] a_old, a_new;
    calc_target(d, tc, tr, oob);
    a_old = 11'(m_row * 40 + m_col);
    a_new = 11'(tr * 40 + tc);
    if (!oob) preload(a_new, code);
    if (!oob && !model_wall(code)) begin
      exp_q.push_back({a_old, 3'b100});
      exp_q.push_back({a_new, 3'b010});
    end
    do_step(d, lat_m, lat_b);
    if (!oob && !model_wall(code)) begin
      m_col = tc; m_row = tr;
      if (code == 3'b101) begin m_score += 10; if (m_dots > 0) m_dots--; end
      if (code == 3'b110) begin m_score += 50; if (m_dots > 0) m_dots--; end
      if (m_score > 65535) m_score = 65535;
    end
  endtask

  task automatic test_reset;
    int wcyc, icyc; logic [13:0] e, o;
    rst = 1'b1; step = 1'b0; dir = 2'b00;
    #2 rst = 1'b0;
    m_col = 19; m_row = 22; m_score = 0; m_dots = 240;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({we_b, addr_b, din_b, moved, blocked} !== 16'd0) begin
      n_fail++; $display("FAIL reset_ports: we/addr/din/moved/blocked=%b, expected all zero", {we_b, addr_b, din_b, moved, blocked});
    end
    n_checks++;
    if (pac_col !== 6'd19 || pac_row !== 5'd22) begin
      n_fail++; $display("FAIL reset_pos: got (%0d,%0d), expected (19,22)", pac_col, pac_row);
    end
    n_checks++;
    if (score !== 16'd0 || dots_left !== 8'd240 || level_clear !== 1'b0) begin
      n_fail++; $display("FAIL reset_score: score=%0d dots=%0d lc=%b, expected 0/240/0", score, dots_left, level_clear);
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.push_back({11'd899, 3'b010});
    wcyc = -1; icyc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (we_b === 1'b1 && wcyc < 0) wcyc = c;
      if (busy === 1'b0) begin icyc = c; break; end
    end
    n_checks++;
    if (wcyc < 0 || icyc !== wcyc + 1) begin
      n_fail++; $display("FAIL init_busy: write cycle %0d, idle cycle %0d, expected idle one cycle after write", wcyc, icyc);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL init_wr_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL init_wr: got %0d/%b, expected %0d/%b", o[13:3], o[2:0], e[13:3], e[2:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_dot_move;
    int lm, lb; logic [13:0] e, o;
    move(2'b00, 3'b101, lm, lb);
    n_checks++;
    if (lm !== 5 || lb !== -1) begin n_fail++; $display("FAIL dot_latency: moved at %0d blocked at %0d, expected moved at 5", lm, lb); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dot_wr_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL dot_wr: got %0d/%b, expected %0d/%b", o[13:3], o[2:0], e[13:3], e[2:0]); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (pac_col !== 6'(m_col) || pac_row !== 5'(m_row) || score !== 16'(m_score) || dots_left !== 8'(m_dots)) begin
      n_fail++; $display("FAIL dot_state: col=%0d row=%0d score=%0d dots=%0d, expected %0d %0d %0d %0d",
                         pac_col, pac_row, score, dots_left, m_col, m_row, m_score, m_dots);
    end
  endtask

  task automatic test_wall;
    int lm, lb;
    logic [2:0] walls [4];
    walls = '{3'b000, 3'b001, 3'b011, 3'b111};
    for (int i = 0; i < 4; i++) begin
      move(2'b00, walls[i], lm, lb);
      n_checks++;
      if (lb !== 4 || lm !== -1) begin n_fail++; $display("FAIL wall_latency code %b: blocked at %0d moved at %0d, expected blocked at 4", walls[i], lb, lm); end
      n_checks++;
      if (obs_q.size() != 0 || pac_col !== 6'(m_col) || score !== 16'(m_score)) begin
        n_fail++; $display("FAIL wall_effect code %b: %0d writes col=%0d score=%0d, expected 0 writes col=%0d score=%0d",
                           walls[i], obs_q.size(), pac_col, score, m_col, m_score);
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_tunnel;
    int lm, lb, sc; logic [13:0] e, o;
    while (m_col != 0) move(2'b10, 3'b100, lm, lb);
    while (m_row != 14) move(2'b01, 3'b100, lm, lb);
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (pac_col !== 6'd0 || pac_row !== 5'd14) begin n_fail++; $display("FAIL tunnel_setup: got (%0d,%0d), expected (0,14)", pac_col, pac_row); end
    sc = m_score;
    for (int pass = 0; pass < 2; pass++) begin
      move((pass == 0) ? 2'b10 : 2'b00, 3'b100, lm, lb);
      n_checks++;
      if (lm !== 5) begin n_fail++; $display("FAIL tunnel_latency pass %0d: moved at %0d, expected 5", pass, lm); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tunnel_wr_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL tunnel_wr: got %0d/%b, expected %0d/%b", o[13:3], o[2:0], e[13:3], e[2:0]); end
      end
      exp_q.delete(); obs_q.delete();
      n_checks++;
      if (pac_col !== ((pass == 0) ? 6'd39 : 6'd0) || score !== 16'(sc)) begin
        n_fail++; $display("FAIL tunnel_pos pass %0d: col=%0d score=%0d, expected col=%0d score=%0d", pass, pac_col, score, (pass == 0) ? 39 : 0, sc);
      end
    end
  endtask

  task automatic test_oob;
    int lm, lb;
    while (m_row != 0) move(2'b01, 3'b100, lm, lb);
    exp_q.delete(); obs_q.delete();
    move(2'b01, 3'b100, lm, lb);
    n_checks++;
    if (lb !== 2 || lm !== -1 || obs_q.size() != 0 || pac_row !== 5'd0) begin
      n_fail++; $display("FAIL oob_up: blocked at %0d moved at %0d writes %0d row %0d, expected blocked at 2, 0 writes, row 0", lb, lm, obs_q.size(), pac_row);
    end
    while (m_row != 29) move(2'b11, 3'b100, lm, lb);
    exp_q.delete(); obs_q.delete();
    move(2'b11, 3'b100, lm, lb);
    n_checks++;
    if (lb !== 2 || lm !== -1 || obs_q.size() != 0 || pac_row !== 5'd29) begin
      n_fail++; $display("FAIL oob_down: blocked at %0d moved at %0d writes %0d row %0d, expected blocked at 2, 0 writes, row 29", lb, lm, obs_q.size(), pac_row);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy_ignore;
    int m0, b0; logic [13:0] e, o;
    preload(11'((m_row - 1) * 40 + m_col), 3'b100);
    exp_q.push_back({11'(m_row * 40 + m_col), 3'b100});
    exp_q.push_back({11'((m_row - 1) * 40 + m_col), 3'b010});
    m0 = n_moved; b0 = n_blocked;
    @(posedge clk); #1 step = 1'b1; dir = 2'b01;
    @(posedge clk); #1 step = 1'b0;
    @(posedge clk); #1 step = 1'b1; dir = 2'b00;
    @(posedge clk); #1 step = 1'b0;
    repeat (14) @(negedge clk);
    m_row = m_row - 1;
    n_checks++;
    if (n_moved - m0 !== 1 || n_blocked - b0 !== 0) begin
      n_fail++; $display("FAIL busy_ignore: %0d moved %0d blocked pulses, expected 1 moved 0 blocked", n_moved - m0, n_blocked - b0);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_wr_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL busy_wr: got %0d/%b, expected %0d/%b", o[13:3], o[2:0], e[13:3], e[2:0]); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (pac_col !== 6'(m_col) || pac_row !== 5'(m_row)) begin
      n_fail++; $display("FAIL busy_pos: got (%0d,%0d), expected (%0d,%0d)", pac_col, pac_row, m_col, m_row);
    end
  endtask

  task automatic test_saturate;
    int lm, lb, bad;
    bad = 0;
    while (m_score + 50 <= 65530) begin
      move((m_col == 0) ? 2'b00 : 2'b10, 3'b110, lm, lb);
      if (lm != 5) bad++;
      exp_q.delete(); obs_q.delete();
    end
    while (m_score < 65530) begin
      move((m_col == 0) ? 2'b00 : 2'b10, 3'b101, lm, lb);
      if (lm != 5) bad++;
      exp_q.delete(); obs_q.delete();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL score_moves: %0d moves not completed at cycle 5, expected 0", bad); end
    n_checks++;
    if (score !== 16'd65530 || dots_left !== 8'd0 || level_clear !== 1'b1) begin
      n_fail++; $display("FAIL score_preload: score=%0d dots=%0d lc=%b, expected 65530/0/1", score, dots_left, level_clear);
    end
    move((m_col == 0) ? 2'b00 : 2'b10, 3'b110, lm, lb);
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (lm !== 5 || score !== 16'd65535 || dots_left !== 8'd0 || pac_col !== 6'(m_col)) begin
      n_fail++; $display("FAIL score_saturate: moved at %0d score=%0d dots=%0d col=%0d, expected 5/65535/0/%0d", lm, score, dots_left, pac_col, m_col);
    end
  endtask

  task automatic test_reset_mid;
    int tc, tr, icyc; bit oob; logic [1:0] d; logic [13:0] e, o;
    d = (m_col == 0) ? 2'b00 : 2'b10;
    calc_target(d, tc, tr, oob);
    preload(11'(tr * 40 + tc), 3'b101);
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1 step = 1'b1; dir = d;
    @(posedge clk); #1 step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (we_b !== 1'b1 || addr_b !== 11'(m_row * 40 + m_col)) begin
      n_fail++; $display("FAIL mid_erase: we=%b addr=%0d, expected we=1 addr=%0d", we_b, addr_b, m_row * 40 + m_col);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (we_b !== 1'b0) begin n_fail++; $display("FAIL mid_we_drop: we=%b, expected 0", we_b); end
    @(negedge clk);
    m_col = 19; m_row = 22; m_score = 0; m_dots = 240;
    n_checks++;
    if (pac_col !== 6'd19 || pac_row !== 5'd22 || score !== 16'd0 || dots_left !== 8'd240 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL mid_reset: (%0d,%0d) score=%0d dots=%0d writes=%0d, expected (19,22) 0 240 0",
                         pac_col, pac_row, score, dots_left, obs_q.size());
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.push_back({11'd899, 3'b010});
    icyc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin icyc = c; break; end
    end
    n_checks++;
    if (icyc < 0) begin n_fail++; $display("FAIL mid_idle: busy never fell, expected idle after redraw"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_wr_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mid_wr: got %0d/%b, expected %0d/%b", o[13:3], o[2:0], e[13:3], e[2:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_dot_move();
    test_wall();
    test_tunnel();
    test_oob();
    test_busy_ignore();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
